imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 120 ++++++++++++
 tb/tb_imem_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: single-outstanding fetch with fixed response latency and a loader write port.
// Define IMEM_MISALIGN_CHECK_EN to fault fetches whose byte address is not word aligned.
module imem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic [31:0]   lk_addr;
  logic [29:0]   lk_word;
  logic [AW-1:0] lk_idx;
  logic          lk_err;
  logic [31:0]   lk_data;

  // With LATENCY==1 the RESP-entry edge is the accepting edge, so look up the live request address.
  assign lk_addr = (state_q == IDLE) ? req_addr : addr_q;
  assign lk_word = 30'((lk_addr - BASE_ADDR) >> 2);
  assign lk_idx  = lk_word[AW-1:0];
  assign lk_data = mem[lk_idx];

`ifdef IMEM_MISALIGN_CHECK_EN
  assign lk_err = (lk_addr < BASE_ADDR) || (lk_word >= 30'(DEPTH)) || (lk_addr[1:0] != 2'b00);
`else
  assign lk_err = (lk_addr < BASE_ADDR) || (lk_word >= 30'(DEPTH));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (LATENCY <= 1) begin
            state_d = RESP;
            rdata_d = lk_err ? '0 : lk_data;
            err_d   = lk_err;
          end else begin
            cnt_d   = 4'(LATENCY - 2);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = lk_err ? '0 : lk_data;
          err_d   = lk_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; a same-edge load lands after the response register samples the old word.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=2 instance and a LATENCY=1 / DEPTH=16 instance.
module tb_imem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        a_req_valid = 1'b0, a_req_ready, a_rsp_valid, a_rsp_ready = 1'b0, a_rsp_err, a_ld_en = 1'b0;
  logic [31:0] a_req_addr = '0, a_rsp_data, a_ld_data = '0;
  logic [9:0]  a_ld_addr = '0;

  logic        b_req_valid = 1'b0, b_req_ready, b_rsp_valid, b_rsp_ready = 1'b0, b_rsp_err, b_ld_en = 1'b0;
  logic [31:0] b_req_addr = '0, b_rsp_data, b_ld_data = '0;
  logic [3:0]  b_ld_addr = '0;

  imem_responder #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(32'h8000_0000)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
    .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data)
  );

  imem_responder #(.DEPTH(16), .LATENCY(1), .BASE_ADDR(32'h8000_0000)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
    .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    a_ld_en = 1'b1; a_ld_addr = idx; a_ld_data = data;
    @(negedge clk);
    a_ld_en = 1'b0;
  endtask

  task automatic load_b(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    b_ld_en = 1'b1; b_ld_addr = idx; b_ld_data = data;
    @(negedge clk);
    b_ld_en = 1'b0;
  endtask

  // Full fetch on instance A: latency counted in cycles after the accepting edge.
  task automatic req_a(input logic [31:0] addr, input logic [31:0] ed, input logic ee, input string tag);
    int unsigned n;
    @(negedge clk);
    chk({tag, "_req_ready"}, 32'(a_req_ready), 32'd1);
    a_req_valid = 1'b1; a_req_addr = addr;
    @(negedge clk);
    a_req_valid = 1'b0; a_req_addr = '0;
    n = 1;
    while (!a_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd2);
    chk({tag, "_data"}, a_rsp_data, ed);
    chk({tag, "_err"}, 32'(a_rsp_err), 32'(ee));
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    chk({tag, "_done"}, 32'(a_rsp_valid), 32'd0);
  endtask

  logic [31:0] b_addr [4] = '{32'h8000_0008, 32'h8000_000C, 32'h8000_0010, 32'h8000_0040};
  logic [31:0] b_exp  [4] = '{32'hB000_0002, 32'hB000_0003, 32'hB000_0004, 32'h0000_0000};
  logic        b_eerr [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    @(negedge clk);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_rsp_data", a_rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(a_rsp_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(a_req_ready), 32'd1);
    chk("rst_b_req_ready", 32'(b_req_ready), 32'd1);

    load_a(10'd0, 32'h0000_0413);
    load_a(10'd1, 32'h00A0_0093);
    load_a(10'd1023, 32'hDEAD_BEEF);

    req_a(32'h8000_0000, 32'h0000_0413, 1'b0, "word0");
    req_a(32'h8000_0004, 32'h00A0_0093, 1'b0, "word1");
    req_a(32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0, "last_word");
    req_a(32'h7FFF_FFFC, 32'h0000_0000, 1'b1, "below_base");
    req_a(32'h8000_1000, 32'h0000_0000, 1'b1, "past_depth");
`ifdef IMEM_MISALIGN_CHECK_EN
    req_a(32'h8000_0002, 32'h0000_0000, 1'b1, "misalign");
`else
    req_a(32'h8000_0002, 32'h0000_0413, 1'b0, "misalign");
`endif

    // Stall in RESP; new requests and a load to the captured word must not disturb the response.
    @(negedge clk);
    a_req_valid = 1'b1; a_req_addr = 32'h8000_0004;
    @(negedge clk);
    a_req_valid = 1'b0;
    @(negedge clk);
    chk("stall_entry_valid", 32'(a_rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      a_req_valid = 1'b1; a_req_addr = 32'h8000_0000;
      a_ld_en = (i == 0); a_ld_addr = 10'd1; a_ld_data = 32'h1111_1111;
      @(negedge clk);
      a_ld_en = 1'b0;
      chk("stall_valid", 32'(a_rsp_valid), 32'd1);
      chk("stall_data", a_rsp_data, 32'h00A0_0093);
      chk("stall_req_ready", 32'(a_req_ready), 32'd0);
    end
    a_req_valid = 1'b0; a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    chk("stall_release_valid", 32'(a_rsp_valid), 32'd0);
    chk("stall_release_ready", 32'(a_req_ready), 32'd1);
    req_a(32'h8000_0004, 32'h1111_1111, 1'b0, "after_load");

    // Load to the captured word on the RESP-entry edge returns the old word.
    @(negedge clk);
    a_req_valid = 1'b1; a_req_addr = 32'h8000_0000;
    @(negedge clk);
    a_req_valid = 1'b0;
    a_ld_en = 1'b1; a_ld_addr = 10'd0; a_ld_data = 32'h2222_2222;
    @(negedge clk);
    a_ld_en = 1'b0;
    chk("rbw_valid", 32'(a_rsp_valid), 32'd1);
    chk("rbw_data", a_rsp_data, 32'h0000_0413);
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    req_a(32'h8000_0000, 32'h2222_2222, 1'b0, "rbw_new");

    // Reset while in WAIT drops the request.
    @(negedge clk);
    a_req_valid = 1'b1; a_req_addr = 32'h8000_0004;
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("wait_rst_pre", 32'(a_req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("wait_rst_async_ready", 32'(a_req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_rst_no_rsp", 32'(a_rsp_valid), 32'd0);
      chk("wait_rst_ready", 32'(a_req_ready), 32'd1);
    end
    req_a(32'h8000_0000, 32'h2222_2222, 1'b0, "post_rst");

    // Reset while in RESP clears outputs immediately.
    @(negedge clk);
    a_req_valid = 1'b1; a_req_addr = 32'h8000_0FFC;
    @(negedge clk);
    a_req_valid = 1'b0;
    @(negedge clk);
    chk("resp_rst_pre", a_rsp_data, 32'hDEAD_BEEF);
    rst = 1'b0;
    #1;
    chk("resp_rst_valid", 32'(a_rsp_valid), 32'd0);
    chk("resp_rst_data", a_rsp_data, 32'd0);
    chk("resp_rst_ready", 32'(a_req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Instance B: LATENCY=1, requests held back-to-back with rsp_ready high.
    load_b(4'd2, 32'hB000_0002);
    load_b(4'd3, 32'hB000_0003);
    load_b(4'd4, 32'hB000_0004);
    @(negedge clk);
    b_rsp_ready = 1'b1; b_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_idle_ready", 32'(b_req_ready), 32'd1);
      chk("b2b_idle_valid", 32'(b_rsp_valid), 32'd0);
      b_req_addr = b_addr[i];
      @(negedge clk);
      chk("b2b_valid", 32'(b_rsp_valid), 32'd1);
      chk("b2b_data", b_rsp_data, b_exp[i]);
      chk("b2b_err", 32'(b_rsp_err), 32'(b_eerr[i]));
      b_req_addr = 32'hFFFF_FFF0;
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_end", 32'(b_rsp_valid), 32'd0);
    b_rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
